// File: rtl/crc_feed_ctrl.sv
// Byte-feed controller for the CRC engine: accepts host writes to CRC_DR and steps the engine
// one byte lane per cycle. Optional holding buffer enabled by CRC_FEED_HOLD_BUF_EN.
module crc_feed_ctrl (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       buffer_write_en,
  input  logic [1:0] bus_size,
  input  logic       reset_chain,
  output logic       buffer_full,
  output logic       read_wait,
  output logic       reset_pending,
  output logic       hb_load,
  output logic       wb_load,
  output logic       crc_calc_en,
  output logic [1:0] byte_sel,
  output logic       crc_reset
);

  typedef enum logic [1:0] {StIdle, StCalc, StRst} state_e;

  state_e     state_q, state_d;
  logic [1:0] wb_size_q, wb_size_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] wb_src_size;
  logic       hb_valid;
  logic       last_byte;

  // Index of the final byte lane for a given write size; size 11 behaves as a word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

  assign last_byte = (state_q == StCalc) && (cnt_q == last_idx(wb_size_q));

`ifdef CRC_FEED_HOLD_BUF_EN
  logic       hb_valid_q, hb_valid_d;
  logic [1:0] hb_size_q, hb_size_d;

  assign hb_valid    = hb_valid_q;
  assign wb_src_size = hb_size_q;

  always_comb begin
    wb_load     = hb_valid_q && ((state_q == StIdle) || last_byte) && !reset_chain;
    buffer_full = hb_valid_q && !wb_load;
    hb_load     = HRESETn && buffer_write_en && !buffer_full && !reset_chain;
    hb_valid_d  = hb_valid_q;
    hb_size_d   = hb_size_q;
    if (reset_chain) begin
      hb_valid_d = 1'b0;
    end else if (hb_load) begin
      // A load coinciding with a drain refills the buffer in the same cycle.
      hb_valid_d = 1'b1;
      hb_size_d  = bus_size;
    end else if (wb_load) begin
      hb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hb_valid_q <= 1'b0;
      hb_size_q  <= 2'b00;
    end else begin
      hb_valid_q <= hb_valid_d;
      hb_size_q  <= hb_size_d;
    end
  end
`else
  assign hb_valid    = 1'b0;
  assign wb_src_size = bus_size;

  // Without a holding buffer the write goes straight into the work buffer.
  always_comb begin
    buffer_full = (state_q != StIdle);
    hb_load     = HRESETn && buffer_write_en && !buffer_full && !reset_chain;
    wb_load     = hb_load;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wb_size_d = wb_size_q;
    if (reset_chain) begin
      state_d = StRst;
      cnt_d   = 2'd0;
    end else if (wb_load) begin
      wb_size_d = wb_src_size;
      cnt_d     = 2'd0;
      state_d   = StCalc;
    end else begin
      case (state_q)
        StCalc: begin
          if (last_byte) begin
            state_d = StIdle;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        StRst:   state_d = StIdle;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= StIdle;
      cnt_q     <= 2'd0;
      wb_size_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wb_size_q <= wb_size_d;
    end
  end

  always_comb begin
    read_wait     = hb_valid || (state_q != StIdle);
    crc_calc_en   = (state_q == StCalc);
    byte_sel      = crc_calc_en ? cnt_q : 2'd0;
    crc_reset     = (state_q == StRst);
    reset_pending = (state_q == StRst);
  end

endmodule

// File: tb/tb_crc_feed_ctrl.sv
// Scoreboard bench for crc_feed_ctrl: stimulus queues expected engine activity per cycle,
// a negedge monitor pops and compares. Covers both CRC_FEED_HOLD_BUF_EN builds.
module tb_crc_feed_ctrl;

`ifdef CRC_FEED_HOLD_BUF_EN
  localparam bit Hold = 1'b1;
`else
  localparam bit Hold = 1'b0;
`endif

  logic       HCLK;
  logic       HRESETn;
  logic       buffer_write_en;
  logic [1:0] bus_size;
  logic       reset_chain;
  logic       buffer_full;
  logic       read_wait;
  logic       reset_pending;
  logic       hb_load;
  logic       wb_load;
  logic       crc_calc_en;
  logic [1:0] byte_sel;
  logic       crc_reset;

  crc_feed_ctrl dut (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .buffer_write_en(buffer_write_en),
    .bus_size       (bus_size),
    .reset_chain    (reset_chain),
    .buffer_full    (buffer_full),
    .read_wait      (read_wait),
    .reset_pending  (reset_pending),
    .hb_load        (hb_load),
    .wb_load        (wb_load),
    .crc_calc_en    (crc_calc_en),
    .byte_sel       (byte_sel),
    .crc_reset      (crc_reset)
  );

  typedef struct {
    bit       is_rst;
    logic [1:0] sel;
    int       cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   next_free = 0;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  always @(posedge HCLK) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endfunction

  // Monitor: every cycle with engine activity must match the head of the queue.
  always @(negedge HCLK) begin
    if (HRESETn) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        chk("missing_output_cycle", cyc, mon_e.cyc);
      end
      if (crc_calc_en || crc_reset || reset_pending) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", int'({crc_calc_en, crc_reset, reset_pending}), 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("output_cycle", cyc, mon_e.cyc);
          chk("crc_reset", int'(crc_reset), int'(mon_e.is_rst));
          chk("reset_pending", int'(reset_pending), int'(mon_e.is_rst));
          chk("crc_calc_en", int'(crc_calc_en), int'(!mon_e.is_rst));
          chk("byte_sel", int'(byte_sel), int'(mon_e.sel));
        end
      end
    end
  end

  // Expected byte lanes for an accepted write in the current cycle.
  task automatic push_write(input logic [1:0] sz);
    int k;
    int first;
    k = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    first = cyc + 1;
    if (Hold) first = (cyc + 2 > next_free) ? cyc + 2 : next_free;
    for (int i = 0; i < k; i++) begin
      exp_t e;
      e.is_rst = 1'b0;
      e.sel    = 2'(i);
      e.cyc    = first + i;
      exp_q.push_back(e);
    end
    next_free = first + k;
  endtask

  task automatic drive(input bit we, input logic [1:0] sz, input bit rc,
                       input bit ef, input bit el, input bit ewb, input bit erw);
    @(posedge HCLK);
    #1;
    buffer_write_en = we;
    bus_size        = sz;
    reset_chain     = rc;
    @(negedge HCLK);
    #1;
    chk("buffer_full", int'(buffer_full), int'(ef));
    chk("hb_load", int'(hb_load), int'(el));
    chk("wb_load", int'(wb_load), int'(ewb));
    chk("read_wait", int'(read_wait), int'(erw));
    if (rc) begin
      exp_t e;
      while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > cyc) exp_q.pop_back();
      e.is_rst = 1'b1;
      e.sel    = 2'd0;
      e.cyc    = cyc + 1;
      exp_q.push_back(e);
      next_free = cyc + 2;
    end else if (el) begin
      push_write(sz);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_buffer_full"}, int'(buffer_full), 0);
    chk({tag, "_read_wait"}, int'(read_wait), 0);
    chk({tag, "_reset_pending"}, int'(reset_pending), 0);
    chk({tag, "_hb_load"}, int'(hb_load), 0);
    chk({tag, "_wb_load"}, int'(wb_load), 0);
    chk({tag, "_crc_calc_en"}, int'(crc_calc_en), 0);
    chk({tag, "_byte_sel"}, int'(byte_sel), 0);
    chk({tag, "_crc_reset"}, int'(crc_reset), 0);
  endtask

  // Single write from IDLE, followed by the full drain back to quiescence.
  task automatic single_write(input logic [1:0] sz);
    int k;
    k = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    drive(1'b1, sz, 1'b0, 1'b0, 1'b1, !Hold, 1'b0);
    for (int i = 1; i <= k; i++) drive(1'b0, 2'b00, 1'b0, !Hold, 1'b0, Hold && (i == 1), 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, Hold);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [1:0] sizes [4];
    sizes = '{2'b10, 2'b01, 2'b11, 2'b00};
    HRESETn         = 1'b0;
    buffer_write_en = 1'b1;
    bus_size        = 2'b10;
    reset_chain     = 1'b0;
    #2;
    check_zero("por");
    buffer_write_en = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);
    #1;
    HRESETn = 1'b1;

    foreach (sizes[i]) single_write(sizes[i]);

`ifdef CRC_FEED_HOLD_BUF_EN
    // Byte then halfword on consecutive cycles: no bubble between them.
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Two words back-to-back, third write stalls until the first word's last byte.
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // reset_chain on byte 2 with the holding buffer occupied.
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    // Word blocks further writes for 4 cycles; next one accepted on return to IDLE.
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // reset_chain on byte 2 of a word.
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // Write coincident with reset_chain is dropped; reset_chain in RST restarts it.
    drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b1, !Hold, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, !Hold, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a word.
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, !Hold, 1'b0);
    drive(1'b0, 2'b00, 1'b0, !Hold, 1'b0, Hold, 1'b1);
    drive(1'b0, 2'b00, 1'b0, !Hold, 1'b0, 1'b0, 1'b1);
    #1;
    HRESETn = 1'b0;
    #1;
    check_zero("async_rst");
    exp_q.delete();
    next_free = 0;
    @(negedge HCLK);
    #1;
    HRESETn = 1'b1;
    single_write(2'b00);

    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
